// File: rtl/worker_share_if.sv
// -----------------------------------------------------------------------------
// worker_share_if
//   Bundles the requester-side and worker-side signals of worker_share_ctrl.
//   Clock and reset are not part of the bundle.
//
//   Requester side : req, rsp_almfull (into ctrl); gnt, done, rsp_valid,
//                    rsp_data (out of ctrl, one slice of DATA_W per requester)
//   Worker side    : wk_valid, wk_data (into ctrl); wk_reset, wk_start,
//                    wk_finish, wk_result_valid, wk_almfull (out of ctrl)
//
//   modport slave  : the controller's view
//   modport master : the environment's view (requesters plus worker)
// -----------------------------------------------------------------------------
interface worker_share_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32
) ();
  logic [N-1:0]        req;
  logic [N-1:0]        gnt;
  logic [N-1:0]        done;
  logic [N-1:0]        rsp_almfull;
  logic [N-1:0]        rsp_valid;
  logic [N*DATA_W-1:0] rsp_data;
  logic                wk_reset;
  logic                wk_start;
  logic                wk_finish;
  logic                wk_result_valid;
  logic                wk_almfull;
  logic                wk_valid;
  logic [DATA_W-1:0]   wk_data;

  modport slave (
    input  req, rsp_almfull, wk_valid, wk_data,
    output gnt, done, rsp_valid, rsp_data,
           wk_reset, wk_start, wk_finish, wk_result_valid, wk_almfull
  );

  modport master (
    output req, rsp_almfull, wk_valid, wk_data,
    input  gnt, done, rsp_valid, rsp_data,
           wk_reset, wk_start, wk_finish, wk_result_valid, wk_almfull
  );
endinterface

// File: rtl/worker_share_ctrl.sv
// -----------------------------------------------------------------------------
// worker_share_ctrl
//   Shares one gated-update worker among N requesters. A round-robin arbiter
//   picks a winner, the controller pulses wk_start, times the WORK phase
//   (WORK_CYCLES cycles, wk_finish on the last), waits in RESULT while the
//   winner applies back-pressure, then pulses done in DRAIN. Its own FSM
//   mirrors the worker's IDLE/WORK/RESULT so both stay in lockstep.
//
//   Ports
//     clk       : clock, all logic on posedge
//     reset_n   : asynchronous active-low reset
//     bus       : worker_share_if.slave (requester and worker signals)
//     stall_cnt : saturating count of RESULT cycles spent with wk_almfull=1
// -----------------------------------------------------------------------------
module worker_share_ctrl #(
  parameter int N           = 4,
  parameter int WORK_CYCLES = 4,
  parameter int DATA_W      = 32,
  parameter int STALL_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  worker_share_if.slave      bus,
  output logic [STALL_W-1:0] stall_cnt
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (WORK_CYCLES > 1) ? $clog2(WORK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WORK,
    S_RESULT,
    S_DRAIN
  } state_t;

  state_t             r_state, w_state_next;
  logic [N-1:0]       r_gnt, w_gnt_next;
  logic [IDX_W-1:0]   r_rr, w_rr_next;
  logic [IDX_W-1:0]   r_win, w_win_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [STALL_W-1:0] r_stall, w_stall_next;
  logic               r_wk_reset;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic               w_almfull;
  logic               w_last;
  logic [N-1:0]       w_rsp_valid;
  logic [N*DATA_W-1:0] w_rsp_data;

  // Round-robin pick: scan from the pointer upward with wrap; first hit wins.
  always_comb begin
    int pos;
    w_found = 1'b0;
    w_pick  = r_rr;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(r_rr) + k) % N;
      if (!w_found && bus.req[pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = pos[IDX_W-1:0];
      end
    end
  end

  // gnt is one-hot or zero, so masking also forces 0 while nothing is granted.
  assign w_almfull = |(bus.rsp_almfull & r_gnt);
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_rr_next    = r_rr;
    w_win_next   = r_win;
    w_cnt_next   = r_cnt;
    w_stall_next = r_stall;
    case (r_state)
      S_IDLE: begin
        // Hold off while the worker is still being resynchronised.
        if (!r_wk_reset && w_found) begin
          w_gnt_next   = N'(1) << w_pick;
          w_win_next   = w_pick;
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_next   = '0;
        w_state_next = S_WORK;
      end
      S_WORK: begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_last) begin
          w_state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (w_almfull) begin
          if (r_stall != {STALL_W{1'b1}}) begin
            w_stall_next = r_stall + 1'b1;
          end
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_gnt_next   = '0;
        w_rr_next    = (r_win == IDX_LAST) ? '0 : r_win + 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_gnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_rr       <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_stall    <= '0;
      r_wk_reset <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_rr       <= w_rr_next;
      r_win      <= w_win_next;
      r_cnt      <= w_cnt_next;
      r_stall    <= w_stall_next;
      // Worker sees reset for one more edge after release, then runs.
      r_wk_reset <= 1'b0;
    end
  end

  // Route worker results to the granted requester only.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rsp
      assign w_rsp_valid[gi]                    = bus.wk_valid & r_gnt[gi];
      assign w_rsp_data[gi*DATA_W +: DATA_W]    = r_gnt[gi] ? bus.wk_data : '0;
    end
  endgenerate

  // Worker controls decode from registered state only.
  assign bus.gnt             = r_gnt;
  assign bus.done            = (r_state == S_DRAIN) ? r_gnt : '0;
  assign bus.wk_reset        = r_wk_reset;
  assign bus.wk_start        = (r_state == S_LAUNCH);
  assign bus.wk_finish       = (r_state == S_WORK) && w_last;
  assign bus.wk_result_valid = (r_state == S_WORK) && w_last;
  assign bus.wk_almfull      = w_almfull;
  assign bus.rsp_valid       = w_rsp_valid;
  assign bus.rsp_data        = w_rsp_data;
  assign stall_cnt           = r_stall;
endmodule
